priority_enc8_3: RTL and testbench
==================================

Name: priority_enc8_3

Overview:
- 8-to-3 priority encoder with active-high enable and registered outputs.
- I7 has the highest priority and I0 the lowest.
- Built structurally from gate-level logic.
- Used wherever the index of the highest-priority active request line is needed, with the result and a valid flag presented one clock later.

Parameters:
- None. All widths are fixed: 8 request inputs, 3-bit encoded output.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset; sampled on the rising edge of clk.
- en  input  1  encoder enable; active high.
- I7  input  1  request line 7 (highest priority).
- I6  input  1  request line 6.
- I5  input  1  request line 5.
- I4  input  1  request line 4.
- I3  input  1  request line 3.
- I2  input  1  request line 2.
- I1  input  1  request line 1.
- I0  input  1  request line 0 (lowest priority).
- O2  output  1  encoded index, MSB (registered).
- O1  output  1  encoded index, middle bit (registered).
- O0  output  1  encoded index, LSB (registered).
- V  output  1  valid: en=1 and at least one request line was high (registered).

Behaviour:
- Reset: when rst=1 at a rising edge, O2, O1, O0 and V all become 0. Reset has priority over every other input.
- Combinational core, evaluated from the current en and I7..I0:
  - O2 = en & (I7 | I6 | I5 | I4)
  - O1 = en & (I7 | I6 | (~I5 & ~I4 & (I3 | I2)))
  - O0 = en & (I7 | (~I6 & I5) | (~I6 & ~I4 & I3) | (~I6 & ~I4 & ~I2 & I1))
  - V = en & (I7 | I6 | I5 | I4 | I3 | I2 | I1 | I0)
- Result: {O2,O1,O0} is the binary index of the highest-numbered high input. Lower-numbered inputs are ignored whenever a higher one is also high.
- Latency: the combinational result is captured on the rising edge of clk. Outputs change only at clock edges, exactly one cycle after the inputs are sampled, with no combinational path from inputs to outputs.
- Enable low: if en=0 at a sampling edge, the outputs become 000 and V=0, regardless of the I lines.
- No request: if en=1 and all I lines are 0, the outputs become 000 and V=0.
- I0 alone: if en=1 and only I0 is high, the outputs become 000 and V=1. V is the only way to tell this case apart from the no-request case.
- Holding: inputs that stay stable across consecutive edges give stable outputs, with no glitches on the registered outputs.
- Reset mid-operation: asserting rst overrides the pending result for that edge. The first edge after rst deasserts captures the then-current inputs normally.
- Unknown inputs: X or Z on the inputs has no defined result; the bench drives only 0 or 1.

Decomposition:
- A shared package is not needed. If the team prefers, a package may hold the constant ENC_W = 3 and the index constants IDX_0..IDX_7 for use in the bench.
- One sub-module is natural: priority_enc4_2, a 4-to-2 priority encoder with a group-active output, instantiated twice.
  - Upper instance covers I7..I4; lower instance covers I3..I0.
  - O2 is the upper group-active output, gated by en.
  - O1 and O0 select between the two instances' outputs using O2.
  - V is the OR of both group-active outputs, gated by en.
  - A single flop bank captures O2, O1, O0 and V, and is cleared by rst.

Test Plan:
- Reset, then en=0, I7=1, others 0 -> after one edge: O=000, V=0 (enable masks the request).
- en=1, only I0=1 -> O=000, V=1. Then en=1 with all I lines 0 -> O=000, V=0.
- Single requests: en=1, only I1=1 -> 001; only I7=1 -> 111; V=1 in both cases.
- Priority with multiple requests, en=1:
  - I2 and I1 -> 010
  - I3 and I1 -> 011
  - I4 and I3 -> 100
  - I5 and I4 -> 101
  - I6 and I3 -> 110
  - All eight lines high -> 111
  - V=1 in every case.
- Latency and reset: change the inputs mid-cycle and check the outputs update only at the next rising edge. Assert rst while en=1 and I7=1 -> outputs become 000, V=0 at that edge. Deassert rst -> 111, V=1 one edge later.
- Exhaustive: all 512 combinations of en and I7..I0 checked against a behavioural priority model, with one-cycle latency.

Source files
------------

// File: rtl/priority_enc8_3_pkg.sv
// -----------------------------------------------------------------------------
// priority_enc8_3_pkg
//   Shared constants for the 8-to-3 priority encoder: the encoded index width
//   and the index value of each request line.
// -----------------------------------------------------------------------------
package priority_enc8_3_pkg;

    localparam int ENC_W = 3;

    localparam logic [ENC_W-1:0] IDX_0 = 3'd0;
    localparam logic [ENC_W-1:0] IDX_1 = 3'd1;
    localparam logic [ENC_W-1:0] IDX_2 = 3'd2;
    localparam logic [ENC_W-1:0] IDX_3 = 3'd3;
    localparam logic [ENC_W-1:0] IDX_4 = 3'd4;
    localparam logic [ENC_W-1:0] IDX_5 = 3'd5;
    localparam logic [ENC_W-1:0] IDX_6 = 3'd6;
    localparam logic [ENC_W-1:0] IDX_7 = 3'd7;

endpackage : priority_enc8_3_pkg

// File: rtl/priority_enc8_3_enc4_2.sv
// -----------------------------------------------------------------------------
// priority_enc8_3_enc4_2
//   Purely combinational 4-to-2 priority encoder (bit 3 highest priority)
//   with a group-active flag. Used twice by priority_enc8_3, once for each
//   nibble of request lines.
//
// Ports
//   req_i [3:0]  request lines, bit 3 has the highest priority
//   idx_o [1:0]  index of the highest set request (00 when none are set)
//   act_o        at least one request line is set
// -----------------------------------------------------------------------------
module priority_enc8_3_enc4_2 (
    input  logic [3:0] req_i,
    output logic [1:0] idx_o,
    output logic       act_o
);

    assign idx_o[1] = req_i[3] | req_i[2];
    // Bit 1 only wins when bit 2 is not set, since bit 2 would claim idx 10.
    assign idx_o[0] = req_i[3] | (~req_i[2] & req_i[1]);
    assign act_o    = req_i[3] | req_i[2] | req_i[1] | req_i[0];

endmodule : priority_enc8_3_enc4_2

// File: rtl/priority_enc8_3.sv
// -----------------------------------------------------------------------------
// priority_enc8_3
//   8-to-3 priority encoder with enable and registered outputs. I7 has the
//   highest priority. The index of the highest set request and a valid flag
//   appear one clock after the inputs are sampled; there is no combinational
//   path from inputs to outputs.
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous active-high reset, clears all outputs
//   en           encoder enable; when low the outputs capture 000 / V=0
//   I7..I0       request lines (I7 highest priority)
//   O2,O1,O0     registered encoded index (O2 is the MSB)
//   V            registered valid: en was high and some request was set
// -----------------------------------------------------------------------------
module priority_enc8_3
    import priority_enc8_3_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic I7,
    input  logic I6,
    input  logic I5,
    input  logic I4,
    input  logic I3,
    input  logic I2,
    input  logic I1,
    input  logic I0,
    output logic O2,
    output logic O1,
    output logic O0,
    output logic V
);

    logic [1:0]       up_idx;
    logic [1:0]       lo_idx;
    logic             up_act;
    logic             lo_act;

    logic [ENC_W-1:0] idx_d;
    logic [ENC_W-1:0] idx_q;
    logic             v_d;
    logic             v_q;

    priority_enc8_3_enc4_2 u_upper (
        .req_i ({I7, I6, I5, I4}),
        .idx_o (up_idx),
        .act_o (up_act)
    );

    priority_enc8_3_enc4_2 u_lower (
        .req_i ({I3, I2, I1, I0}),
        .idx_o (lo_idx),
        .act_o (lo_act)
    );

    // Any request in the upper nibble outranks the whole lower nibble, so
    // the upper group-active flag is both the index MSB and the select for
    // the two low index bits.
    assign idx_d[2]   = en & up_act;
    assign idx_d[1:0] = {2{en}} & (up_act ? up_idx : lo_idx);
    assign v_d        = en & (up_act | lo_act);

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q <= '0;
            v_q   <= 1'b0;
        end else begin
            idx_q <= idx_d;
            v_q   <= v_d;
        end
    end

    assign O2 = idx_q[2];
    assign O1 = idx_q[1];
    assign O0 = idx_q[0];
    assign V  = v_q;

endmodule : priority_enc8_3

// File: tb/tb_priority_enc8_3.sv
// -----------------------------------------------------------------------------
// tb_priority_enc8_3
//   Self-checking bench for priority_enc8_3. A behavioural priority model
//   predicts {O2,O1,O0,V} for every edge; predictions are queued at the rising
//   edge and compared against the DUT at the following falling edge. Directed
//   steps additionally check hand-computed literal values.
// -----------------------------------------------------------------------------
module tb_priority_enc8_3;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] req;
    logic       O2, O1, O0, V;

    int checks = 0;
    int errors = 0;

    logic [3:0] exp_q[$];

    priority_enc8_3 dut (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .I7  (req[7]),
        .I6  (req[6]),
        .I5  (req[5]),
        .I4  (req[4]),
        .I3  (req[3]),
        .I2  (req[2]),
        .I1  (req[1]),
        .I0  (req[0]),
        .O2  (O2),
        .O1  (O1),
        .O0  (O0),
        .V   (V)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- behavioural model ----------------
    // Returns {index, valid}: the number of the highest set line, scanning
    // from 7 downwards.
    function automatic logic [3:0] model(input logic e, input logic [7:0] r);
        if (!e) return 4'b0000;
        for (int k = 7; k >= 0; k--) begin
            if (r[k]) return {k[2:0], 1'b1};
        end
        return 4'b0000;
    endfunction

    task automatic check(input string name, input logic [3:0] got,
                         input logic [3:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got {O2,O1,O0,V}=%b expected %b at %0t",
                     name, got, want, $time);
        end
    endtask

    // ---------------- scoreboard ----------------
    always @(posedge clk) begin
        exp_q.push_back(rst ? 4'b0000 : model(en, req));
    end

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            check("scoreboard", {O2, O1, O0, V}, exp_q.pop_front());
        end
    end

    // ---------------- driver tasks ----------------
    // Inputs change 2 time units after a rising edge, well away from both
    // edges used for sampling.
    task automatic drive(input logic r, input logic e, input logic [7:0] i);
        @(posedge clk);
        #2;
        rst = r;
        en  = e;
        req = i;
    endtask

    // Drive, let one edge capture it, then check a literal expectation.
    task automatic step(input string name, input logic r, input logic e,
                        input logic [7:0] i, input logic [3:0] want);
        drive(r, e, i);
        @(posedge clk);
        #1;
        check(name, {O2, O1, O0, V}, want);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1;
        en  = 1'b0;
        req = 8'h00;

        // Pin the model with hand-computed values.
        check("model_i0_only", model(1'b1, 8'b0000_0001), 4'b0001);
        check("model_i2_i1",   model(1'b1, 8'b0000_0110), 4'b0101);
        check("model_i6_i3",   model(1'b1, 8'b0100_1000), 4'b1101);
        check("model_en_low",  model(1'b0, 8'b1000_0000), 4'b0000);

        repeat (2) @(posedge clk);
        #1;
        check("reset_state", {O2, O1, O0, V}, 4'b0000);

        step("en_low_masks", 1'b0, 1'b0, 8'b1000_0000, 4'b0000);
        step("i0_only",      1'b0, 1'b1, 8'b0000_0001, 4'b0001);
        step("no_request",   1'b0, 1'b1, 8'b0000_0000, 4'b0000);
        step("i1_only",      1'b0, 1'b1, 8'b0000_0010, 4'b0011);
        step("i7_only",      1'b0, 1'b1, 8'b1000_0000, 4'b1111);
        step("i2_i1",        1'b0, 1'b1, 8'b0000_0110, 4'b0101);
        step("i3_i1",        1'b0, 1'b1, 8'b0000_1010, 4'b0111);
        step("i4_i3",        1'b0, 1'b1, 8'b0001_1000, 4'b1001);
        step("i5_i4",        1'b0, 1'b1, 8'b0011_0000, 4'b1011);
        step("i6_i3",        1'b0, 1'b1, 8'b0100_1000, 4'b1101);
        step("all_high",     1'b0, 1'b1, 8'b1111_1111, 4'b1111);

        // Latency: outputs hold 111/1 after a mid-cycle input change until
        // the next rising edge.
        drive(1'b0, 1'b1, 8'b0000_0010);
        #1;
        check("hold_before_edge", {O2, O1, O0, V}, 4'b1111);
        @(posedge clk);
        #1;
        check("update_after_edge", {O2, O1, O0, V}, 4'b0011);

        // Reset overrides a pending I7 request, then the request appears.
        drive(1'b0, 1'b1, 8'b1000_0000);
        step("rst_overrides", 1'b1, 1'b1, 8'b1000_0000, 4'b0000);
        step("after_rst",     1'b0, 1'b1, 8'b1000_0000, 4'b1111);
        step("hold_stable",   1'b0, 1'b1, 8'b1000_0000, 4'b1111);

        // Exhaustive sweep of en and I7..I0; checked by the scoreboard.
        for (int k = 0; k < 512; k++) begin
            logic [8:0] v;
            v = 9'(k);
            drive(1'b0, v[8], v[7:0]);
        end

        // Random traffic with occasional reset pulses.
        for (int k = 0; k < 300; k++) begin
            drive(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0),
                  8'($urandom_range(0, 255)));
        end

        // Drain the queue.
        drive(1'b0, 1'b0, 8'h00);
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_priority_enc8_3
